// File: rtl/i2c_link_tx_scheduler.sv
// Outbound pong-link frame scheduler: arbitrates BALL/LOSE requests and writes ball state to the peer as I2C register writes.
// Optional feature macro LINK_CHECKSUM_EN appends an XOR checksum byte (reg6) to every frame.
module i2c_link_tx_scheduler #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         MAX_RETRY   = 3,
  parameter int         TIMEOUT_CYC = 250000,
  parameter int         BACKOFF_CYC = 2500
) (
  input  logic       clk_25MHZ,
  input  logic       reset_n,
  input  logic       ball_req,
  input  logic       lose_req,
  input  logic [9:0] ball_y,
  input  logic [7:0] ball_vy,
  input  logic [1:0] gravity_cnt,
  input  logic       fast_ball,
  output logic       m_start,
  output logic [6:0] m_dev_addr,
  output logic [7:0] m_reg_addr,
  output logic [7:0] m_data,
  input  logic       m_ready,
  input  logic       m_done,
  input  logic       m_ack_err,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_fail
);

  typedef enum logic [2:0] {IDLE, LATCH, ISSUE, WAIT_ACK, BACKOFF, DONE, FAIL} state_t;

  localparam int          BO_W      = (BACKOFF_CYC > 1) ? $clog2(BACKOFF_CYC) : 1;
  localparam logic [BO_W-1:0] BO_LAST = BO_W'(BACKOFF_CYC - 1);
  localparam logic [17:0] TMO_LAST  = 18'(TIMEOUT_CYC - 1);
  localparam logic [17:0] TMO_SAT   = 18'h3FFFF;
  localparam logic [1:0]  RETRY_MAX = 2'(MAX_RETRY);
`ifdef LINK_CHECKSUM_EN
  localparam logic [2:0]  LAST_IDX  = 3'd6;
`else
  localparam logic [2:0]  LAST_IDX  = 3'd5;
`endif

  state_t            state_r;
  logic              ball_req_d_r, lose_req_d_r;
  logic              pend_ball_r, pend_lose_r;
  logic [9:0]        y_r;
  logic [7:0]        vy_r;
  logic [1:0]        grav_r;
  logic              fast_r, win_r;
  logic [2:0]        byte_idx_r;
  logic [1:0]        retry_r;
  logic [17:0]       tmo_r;
  logic [BO_W-1:0]   bo_cnt_r;
  logic              ball_rise_s, lose_rise_s;
  logic [2:0]        next_idx_s;

  // Register map of one frame; reg5 (win flag) is the byte the peer treats as end-of-frame.
  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [9:0] y,
                                            input logic [7:0] vy, input logic [1:0] g,
                                            input logic f, input logic w);
    logic [7:0] b;
    case (idx)
      3'd0:    b = {y[9:8], 6'b000000};
      3'd1:    b = y[7:0];
      3'd2:    b = vy;
      3'd3:    b = {6'b000000, g};
      3'd4:    b = {7'b0000000, f};
      3'd5:    b = {7'b0000000, w};
`ifdef LINK_CHECKSUM_EN
      3'd6:    b = {y[9:8], 6'b000000} ^ y[7:0] ^ vy ^ {6'b000000, g}
                   ^ {7'b0000000, f} ^ {7'b0000000, w};
`endif
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign ball_rise_s = ball_req & ~ball_req_d_r;
  assign lose_rise_s = lose_req & ~lose_req_d_r;
  assign next_idx_s  = byte_idx_r + 3'd1;
  assign m_dev_addr  = SLAVE_ADDR;

  // Request capture plus the frame sequencing FSM with registered master-side outputs.
  always_ff @(posedge clk_25MHZ) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      ball_req_d_r <= 1'b0;
      lose_req_d_r <= 1'b0;
      pend_ball_r  <= 1'b0;
      pend_lose_r  <= 1'b0;
      y_r          <= 10'd0;
      vy_r         <= 8'd0;
      grav_r       <= 2'd0;
      fast_r       <= 1'b0;
      win_r        <= 1'b0;
      byte_idx_r   <= 3'd0;
      retry_r      <= 2'd0;
      tmo_r        <= 18'd0;
      bo_cnt_r     <= '0;
      m_start      <= 1'b0;
      m_reg_addr   <= 8'd0;
      m_data       <= 8'd0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      frame_fail   <= 1'b0;
    end else begin
      ball_req_d_r <= ball_req;
      lose_req_d_r <= lose_req;
      frame_done   <= 1'b0;
      frame_fail   <= 1'b0;
      // New edges set flags first so that acceptance below merges a duplicate edge.
      if (ball_rise_s) pend_ball_r <= 1'b1;
      if (lose_rise_s) pend_lose_r <= 1'b1;

      case (state_r)
        IDLE: begin
          m_start <= 1'b0;
          if (pend_lose_r) begin
            pend_lose_r <= 1'b0;
            win_r       <= 1'b1;
            busy        <= 1'b1;
            state_r     <= LATCH;
          end else if (pend_ball_r) begin
            pend_ball_r <= 1'b0;
            win_r       <= 1'b0;
            busy        <= 1'b1;
            state_r     <= LATCH;
          end else begin
            busy <= 1'b0;
          end
        end
        LATCH: begin
          y_r        <= ball_y;
          vy_r       <= ball_vy;
          grav_r     <= gravity_cnt;
          fast_r     <= fast_ball;
          byte_idx_r <= 3'd0;
          retry_r    <= 2'd0;
          m_start    <= 1'b1;
          m_reg_addr <= 8'd0;
          m_data     <= frame_byte(3'd0, ball_y, ball_vy, gravity_cnt, fast_ball, win_r);
          state_r    <= ISSUE;
        end
        ISSUE: begin
          if (m_ready) begin
            m_start <= 1'b0;
            tmo_r   <= 18'd0;
            state_r <= WAIT_ACK;
          end else begin
            m_start <= 1'b1;
          end
        end
        WAIT_ACK: begin
          // An error flagged together with m_done still counts as a failed byte.
          if (m_ack_err || (tmo_r == TMO_LAST)) begin
            if (retry_r < RETRY_MAX) begin
              retry_r  <= retry_r + 2'd1;
              bo_cnt_r <= '0;
              state_r  <= BACKOFF;
            end else begin
              frame_fail <= 1'b1;
              state_r    <= FAIL;
            end
          end else if (m_done) begin
            if (byte_idx_r == LAST_IDX) begin
              frame_done <= 1'b1;
              state_r    <= DONE;
            end else begin
              byte_idx_r <= next_idx_s;
              m_start    <= 1'b1;
              m_reg_addr <= {5'd0, next_idx_s};
              m_data     <= frame_byte(next_idx_s, y_r, vy_r, grav_r, fast_r, win_r);
              state_r    <= ISSUE;
            end
          end else if (tmo_r != TMO_SAT) begin
            tmo_r <= tmo_r + 18'd1;
          end else begin
            tmo_r <= tmo_r;
          end
        end
        BACKOFF: begin
          // The retry resends the whole frame from the original snapshot.
          if (bo_cnt_r == BO_LAST) begin
            byte_idx_r <= 3'd0;
            m_start    <= 1'b1;
            m_reg_addr <= 8'd0;
            m_data     <= frame_byte(3'd0, y_r, vy_r, grav_r, fast_r, win_r);
            state_r    <= ISSUE;
          end else begin
            bo_cnt_r <= bo_cnt_r + 1'b1;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        FAIL: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          m_start <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_link_tx_scheduler.sv
// Directed bench for i2c_link_tx_scheduler with a reactive I2C master model.
// Build with LINK_CHECKSUM_EN defined to also exercise the reg6 checksum byte.
module tb_i2c_link_tx_scheduler;

  localparam int TMO = 100;
  localparam int BO  = 2500;
`ifdef LINK_CHECKSUM_EN
  localparam int NB = 7;
`else
  localparam int NB = 6;
`endif
  localparam logic [6:0][7:0] F_BALL = {8'hDB, 8'h00, 8'h01, 8'h02, 8'hFD, 8'hA5, 8'h80};
  localparam logic [6:0][7:0] F_LOSE = {8'hDA, 8'h01, 8'h01, 8'h02, 8'hFD, 8'hA5, 8'h80};

  logic       clk_25MHZ = 1'b0;
  logic       reset_n, ball_req, lose_req, fast_ball, m_ready, m_done, m_ack_err;
  logic [9:0] ball_y;
  logic [7:0] ball_vy;
  logic [1:0] gravity_cnt;
  logic       m_start, busy, frame_done, frame_fail;
  logic [6:0] m_dev_addr;
  logic [7:0] m_reg_addr, m_data;
  int vectors = 0;
  int miscompares = 0;
  int n;

  i2c_link_tx_scheduler #(.SLAVE_ADDR(7'h50), .MAX_RETRY(3), .TIMEOUT_CYC(TMO), .BACKOFF_CYC(BO)) dut (
    .clk_25MHZ(clk_25MHZ), .reset_n(reset_n), .ball_req(ball_req), .lose_req(lose_req),
    .ball_y(ball_y), .ball_vy(ball_vy), .gravity_cnt(gravity_cnt), .fast_ball(fast_ball),
    .m_start(m_start), .m_dev_addr(m_dev_addr), .m_reg_addr(m_reg_addr), .m_data(m_data),
    .m_ready(m_ready), .m_done(m_done), .m_ack_err(m_ack_err), .busy(busy),
    .frame_done(frame_done), .frame_fail(frame_fail));

  always #20 clk_25MHZ = ~clk_25MHZ;

  initial begin
    #(40 * 200000);
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // resp: 0 = no answer, 1 = ACK, 2 = NACK. Always entered and left on a negedge.
  task automatic do_byte(input logic [7:0] er, input logic [7:0] ed, input int resp, input int stall);
    int w;
    w = 0;
    while (m_start !== 1'b1 && w < 20000) begin
      @(negedge clk_25MHZ);
      w++;
    end
    chk("m_start_seen", m_start, 1);
    chk("m_dev_addr", m_dev_addr, 7'h50);
    chk("m_reg_addr", m_reg_addr, er);
    chk("m_data", m_data, ed);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk_25MHZ);
      chk("stall_start", m_start, 1);
      chk("stall_data", m_data, ed);
    end
    m_ready = 1'b1;
    @(negedge clk_25MHZ);
    m_ready = 1'b0;
    chk("start_drop", m_start, 0);
    if (resp != 0) begin
      m_done    = (resp == 1);
      m_ack_err = (resp == 2);
      @(negedge clk_25MHZ);
      m_done    = 1'b0;
      m_ack_err = 1'b0;
    end
  endtask

  task automatic ack_frame(input logic [6:0][7:0] f);
    for (int i = 0; i < NB; i++) do_byte(8'(i), f[i], 1, 0);
    chk("frame_done_pulse", frame_done, 1);
    chk("frame_fail_low", frame_fail, 0);
    @(negedge clk_25MHZ);
    chk("frame_done_end", frame_done, 0);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    reset_n = 1'b0; ball_req = 1'b0; lose_req = 1'b0; m_ready = 1'b0; m_done = 1'b0;
    m_ack_err = 1'b0; ball_y = 10'h2A5; ball_vy = 8'hFD; gravity_cnt = 2'd2; fast_ball = 1'b1;
    repeat (3) @(negedge clk_25MHZ);
    chk("rst_m_start", m_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_fail", frame_fail, 0);
    chk("rst_reg", m_reg_addr, 0);
    chk("rst_data", m_data, 0);
    chk("rst_dev", m_dev_addr, 7'h50);
    reset_n = 1'b1;
    @(negedge clk_25MHZ);

    // Test 1: BALL frame with latency, stall and snapshot checks.
    ball_req = 1'b1;
    @(negedge clk_25MHZ);
    chk("t1_busy_pend", busy, 0);
    @(negedge clk_25MHZ);
    chk("t1_busy_latch", busy, 1);
    chk("t1_start_latch", m_start, 0);
    @(negedge clk_25MHZ);
    chk("t1_start_issue", m_start, 1);
    do_byte(8'd0, F_BALL[0], 1, 2);
    ball_y = 10'h3FF; ball_vy = 8'h11; gravity_cnt = 2'd1; fast_ball = 1'b0; ball_req = 1'b0;
    for (int i = 1; i < NB; i++) do_byte(8'(i), F_BALL[i], 1, 0);
    chk("t1_done", frame_done, 1);
    chk("t1_busy_done", busy, 1);
    @(negedge clk_25MHZ);
    chk("t1_done_end", frame_done, 0);
    chk("t1_busy_idle", busy, 0);

    // Test 2: simultaneous requests, LOSE first then BALL.
    ball_y = 10'h2A5; ball_vy = 8'hFD; gravity_cnt = 2'd2; fast_ball = 1'b1;
    ball_req = 1'b1; lose_req = 1'b1;
    @(negedge clk_25MHZ);
    ball_req = 1'b0; lose_req = 1'b0;
    ack_frame(F_LOSE);
    ack_frame(F_BALL);

    // Test 3: NACK on reg3, backoff, full resend from reg0.
    ball_req = 1'b1;
    for (int i = 0; i < 4; i++) do_byte(8'(i), F_BALL[i], (i == 3) ? 2 : 1, 0);
    ball_req = 1'b0;
    chk("t3_busy_backoff", busy, 1);
    n = 0;
    while (!m_start && n < 10000) begin @(negedge clk_25MHZ); n++; end
    chk("t3_backoff_len", n, BO);
    ack_frame(F_BALL);

    // Test 4: no m_done ever -> 4 timed-out attempts then FAIL.
    ball_req = 1'b1;
    for (int a = 0; a < 4; a++) begin
      do_byte(8'd0, F_BALL[0], 0, 0);
      ball_req = 1'b0;
      n = 0;
      while (!m_start && !frame_fail && n < 10000) begin @(negedge clk_25MHZ); n++; end
      if (a < 3) begin
        chk("t4_retry_gap", n, TMO + BO);
        chk("t4_no_fail", frame_fail, 0);
      end else begin
        chk("t4_fail_gap", n, TMO);
        chk("t4_fail_pulse", frame_fail, 1);
      end
    end
    chk("t4_no_done", frame_done, 0);
    @(negedge clk_25MHZ);
    chk("t4_fail_end", frame_fail, 0);
    chk("t4_busy_idle", busy, 0);

    // Test 5: reset while waiting on reg2, with a LOSE request pending.
    ball_req = 1'b1;
    @(negedge clk_25MHZ);
    ball_req = 1'b0; lose_req = 1'b1;
    @(negedge clk_25MHZ);
    lose_req = 1'b0;
    do_byte(8'd0, F_BALL[0], 1, 0);
    do_byte(8'd1, F_BALL[1], 1, 0);
    do_byte(8'd2, F_BALL[2], 0, 0);
    reset_n = 1'b0;
    @(negedge clk_25MHZ);
    chk("t5_start", m_start, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", frame_done, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_25MHZ);
      chk("t5_idle_busy", busy, 0);
      chk("t5_idle_start", m_start, 0);
    end
    chk("t5_dev", m_dev_addr, 7'h50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
